// File: rtl/mealy_det_pkg.sv
// ============================================================================
// Module      : mealy_det_pkg
// Description : Shared constants and elaboration-time helpers (clog2, KMP
//               prefix fallback) for the Mealy pattern detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mealy_det_pkg;

  localparam int          DEF_PAT_W   = 4;
  localparam logic [15:0] DEF_PATTERN = 16'b1011;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic logic arr_bit(input logic [15:0] pat, input int pat_w, input int i);
    int idx;
    idx = pat_w - 1 - i;
    return pat[idx[3:0]];
  endfunction

  // Longest k <= kmax such that the last k bits of (prefix_s, xb) equal the
  // first k pattern bits.
  function automatic int border(input logic [15:0] pat, input int pat_w,
                                input int s, input logic xb, input int kmax);
    int   pos;
    logic sb;
    logic ok;
    for (int k = kmax; k >= 1; k--) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        pos = s + 1 - k + i;
        sb  = (pos == s) ? xb : arr_bit(pat, pat_w, pos);
        if (sb != arr_bit(pat, pat_w, i)) ok = 1'b0;
      end
      if (ok) return k;
    end
    return 0;
  endfunction

  function automatic int next_of(input logic [15:0] pat, input int pat_w,
                                 input bit overlap, input int s, input logic xb);
    if (s >= pat_w) return 0;
    if (s == pat_w - 1 && xb == arr_bit(pat, pat_w, pat_w - 1))
      return overlap ? border(pat, pat_w, s, xb, pat_w - 1) : 0;
    if (xb == arr_bit(pat, pat_w, s))
      return s + 1;
    return border(pat, pat_w, s, xb, s);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mealy_det_next_state.sv
// ============================================================================
// Module      : mealy_det_next_state
// Description : Combinational next-state lookup; the table is built from
//               PATTERN at elaboration time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mealy_det_next_state
  import mealy_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter bit               OVERLAP = 1'b1
) (
  input  logic [clog2(PAT_W)-1:0] state,
  input  logic                    x,
  output logic [clog2(PAT_W)-1:0] next_state
);

  localparam int          SW    = clog2(PAT_W);
  localparam int          DEPTH = 1 << SW;
  localparam logic [15:0] PAT16 = 16'(PATTERN);

  logic [SW-1:0] tbl0 [DEPTH];
  logic [SW-1:0] tbl1 [DEPTH];

  // Unreachable encodings (state >= PAT_W) map back to the empty prefix.
  for (genvar s = 0; s < DEPTH; s++) begin : g_tbl
    localparam logic [SW-1:0] N0 = SW'(next_of(PAT16, PAT_W, OVERLAP, s, 1'b0));
    localparam logic [SW-1:0] N1 = SW'(next_of(PAT16, PAT_W, OVERLAP, s, 1'b1));
    assign tbl0[s] = N0;
    assign tbl1[s] = N1;
  end

  assign next_state = x ? tbl1[state] : tbl0[state];

endmodule

`default_nettype wire

// File: rtl/mealy_pattern_detector.sv
// ============================================================================
// Module      : mealy_pattern_detector
// Description : Serial PAT_W-bit Mealy pattern detector with saturating match
//               counter. Optional registered flag Y_q via MEALY_DET_REG_OUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mealy_pattern_detector
  import mealy_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    x,
  input  logic                    x_valid,
  input  logic                    clear,
  output logic                    Y,
  output logic [clog2(PAT_W)-1:0] state,
  output logic [CNT_W-1:0]        match_cnt,
  output logic                    cnt_sat,
  output logic                    Y_q
);

  localparam int               SW      = clog2(PAT_W);
  localparam logic [SW-1:0]    LAST    = SW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SW-1:0] next_state;

  mealy_det_next_state #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP)
  ) u_next (
    .state      (state),
    .x          (x),
    .next_state (next_state)
  );

  assign Y = x_valid & (state == LAST) & (x == PATTERN[0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= '0;
    else if (x_valid)
      state <= next_state;
  end

  // clear wins over a coincident match; sat flag sets on reaching all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else if (clear) begin
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else if (Y) begin
      if (match_cnt != CNT_MAX) match_cnt <= match_cnt + 1'b1;
      if (match_cnt >= CNT_MAX - 1'b1) cnt_sat <= 1'b1;
    end
  end

`ifdef MEALY_DET_REG_OUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      Y_q <= 1'b0;
    else
      Y_q <= Y;
  end
`else
  assign Y_q = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mealy_pattern_detector.sv
// ============================================================================
// Module      : tb_mealy_pattern_detector
// Description : Self-checking bench: vector table plus history-based model
//               feeding a scoreboard; three DUT configurations share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mealy_pattern_detector;

  localparam logic [3:0] PAT = 4'b1011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic x = 1'b0, x_valid = 1'b0, clear = 1'b0;

  logic       y_ov, y_nov, y_sat, yq_ov, yq_nov, yq_sat;
  logic [1:0] st_ov, st_nov, st_sat;
  logic [7:0] cnt_ov, cnt_nov;
  logic [1:0] cnt_sat2;
  logic       sat_ov, sat_nov, sat_sat;

  always #5 clk = ~clk;

  mealy_pattern_detector dut_ov (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .clear(clear),
    .Y(y_ov), .state(st_ov), .match_cnt(cnt_ov), .cnt_sat(sat_ov), .Y_q(yq_ov));

  mealy_pattern_detector #(.OVERLAP(1'b0)) dut_nov (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .clear(clear),
    .Y(y_nov), .state(st_nov), .match_cnt(cnt_nov), .cnt_sat(sat_nov), .Y_q(yq_nov));

  mealy_pattern_detector #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .clear(clear),
    .Y(y_sat), .state(st_sat), .match_cnt(cnt_sat2), .cnt_sat(sat_sat), .Y_q(yq_sat));

  int checks = 0;
  int failures = 0;

  typedef struct {
    int st_ov; int st_nov; int c8; int c2; bit s8; bit s2; bit yq;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit rst_before; logic bx; logic bv; logic ey; int est;
  } vec_t;
  vec_t vecs[13];

  // Reference model: raw history of accepted bits, newest in bit 0.
  logic [15:0] hist;
  int acc, accn, m_st_ov, m_st_nov, m_c8, m_c2;
  bit m_s8, m_s2;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int longest(input logic [15:0] h, input int n);
    int kmax;
    bit ok;
    kmax = (n < 3) ? n : 3;
    for (int k = kmax; k >= 1; k--) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++)
        if (h[k-1-i] != PAT[3-i]) ok = 1'b0;
      if (ok) return k;
    end
    return 0;
  endfunction

  task automatic model_reset();
    hist = '0; acc = 0; accn = 0; m_st_ov = 0; m_st_nov = 0;
    m_c8 = 0; m_c2 = 0; m_s8 = 1'b0; m_s2 = 1'b0;
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; x_valid = 1'b0; clear = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic bx, input logic bv, input logic bc, output logic yo);
    logic ey, eyn;
    exp_t e, g;
    @(negedge clk);
    x = bx; x_valid = bv; clear = bc;
    #1;
    ey  = bv && acc  >= 3 && {hist[2:0], bx} == PAT;
    eyn = bv && accn >= 3 && {hist[2:0], bx} == PAT;
    chk("y_ov", y_ov, ey);
    chk("y_nov", y_nov, eyn);
    chk("y_sat", y_sat, ey);
    yo = y_ov;
    if (bv) begin
      hist = {hist[14:0], bx};
      acc++;
      accn = eyn ? 0 : accn + 1;
      m_st_ov  = longest(hist, acc);
      m_st_nov = longest(hist, accn);
    end
    if (bc) begin
      m_c8 = 0; m_c2 = 0; m_s8 = 1'b0; m_s2 = 1'b0;
    end else if (ey) begin
      if (m_c8 < 255) m_c8++;
      if (m_c2 < 3) m_c2++;
      if (m_c8 == 255) m_s8 = 1'b1;
      if (m_c2 == 3) m_s2 = 1'b1;
    end
    e.st_ov = m_st_ov; e.st_nov = m_st_nov; e.c8 = m_c8; e.c2 = m_c2;
    e.s8 = m_s8; e.s2 = m_s2;
`ifdef MEALY_DET_REG_OUT_EN
    e.yq = ey;
`else
    e.yq = 1'b0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty actual=0 expected=1");
    end else begin
      g = sb.pop_front();
      chk("state_ov", st_ov, g.st_ov);
      chk("state_nov", st_nov, g.st_nov);
      chk("state_sat", st_sat, g.st_ov);
      chk("cnt_ov", cnt_ov, g.c8);
      chk("cnt_sat2", cnt_sat2, g.c2);
      chk("sat_ov", sat_ov, g.s8);
      chk("sat_sat", sat_sat, g.s2);
      chk("yq_ov", yq_ov, g.yq);
      chk("yq_sat", yq_sat, g.yq);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic yo;
    // Fallback stream 1,0,1,0,1,1 then overlap stream 1,0,1,1,0,1,1.
    vecs[0]  = '{1, 1, 1, 0, 1};  vecs[1]  = '{0, 0, 1, 0, 2};
    vecs[2]  = '{0, 1, 1, 0, 3};  vecs[3]  = '{0, 0, 1, 0, 2};
    vecs[4]  = '{0, 1, 1, 0, 3};  vecs[5]  = '{0, 1, 1, 1, 1};
    vecs[6]  = '{1, 1, 1, 0, 1};  vecs[7]  = '{0, 0, 1, 0, 2};
    vecs[8]  = '{0, 1, 1, 0, 3};  vecs[9]  = '{0, 1, 1, 1, 1};
    vecs[10] = '{0, 0, 1, 0, 2};  vecs[11] = '{0, 1, 1, 0, 3};
    vecs[12] = '{0, 1, 1, 1, 1};

    model_reset();
    #1;
    chk("rst_state", st_ov, 0);
    chk("rst_cnt", cnt_ov, 0);
    chk("rst_sat", sat_ov, 0);
    chk("rst_y", y_ov, 0);
    chk("rst_yq", yq_ov, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rst_before) do_reset();
      step(vecs[i].bx, vecs[i].bv, 1'b0, yo);
      chk("vec_y", yo, vecs[i].ey);
      chk("vec_state", st_ov, vecs[i].est);
    end
    chk("overlap_cnt", cnt_ov, 2);
    chk("nonoverlap_cnt", cnt_nov, 1);

    // x_valid low: everything holds even with matching-looking x.
    for (int i = 0; i < 5; i++) step(1'(i), 1'b0, 1'b0, yo);
    chk("hold_state", st_ov, 1);
    chk("hold_cnt", cnt_ov, 2);

    // Asynchronous reset after prefix 1,0,1 discards it; no match counted.
    do_reset();
    step(1, 1, 0, yo); step(0, 1, 0, yo); step(1, 1, 0, yo);
    chk("pre_rst_state", st_ov, 3);
    @(negedge clk);
    x = 1'b1; x_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("midrst_state", st_ov, 0);
    chk("midrst_y", y_ov, 0);
    chk("midrst_cnt", cnt_ov, 0);
    @(posedge clk); #1;
    chk("midrst_cnt_edge", cnt_ov, 0);
    @(negedge clk);
    reset = 1'b0; x_valid = 1'b0;
    model_reset();

    // Saturation on the 2-bit counter, then clear coinciding with a match.
    step(1, 1, 0, yo); step(0, 1, 0, yo); step(1, 1, 0, yo); step(1, 1, 0, yo);
    for (int m = 0; m < 2; m++) begin
      step(0, 1, 0, yo); step(1, 1, 0, yo); step(1, 1, 0, yo);
    end
    chk("sat3_cnt", cnt_sat2, 3);
    chk("sat3_flag", sat_sat, 1);
    step(0, 1, 0, yo); step(1, 1, 0, yo); step(1, 1, 0, yo);
    chk("sat4_cnt", cnt_sat2, 3);
    step(0, 1, 0, yo); step(1, 1, 0, yo); step(1, 1, 1, yo);
    chk("clr_match_y", yo, 1);
    chk("clr_cnt", cnt_sat2, 0);
    chk("clr_flag", sat_sat, 0);
    chk("clr_state", st_ov, 1);
    step(0, 0, 0, yo);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
